// File: rtl/rgmii_to_gmii_rx.sv
// rtl/rgmii_to_gmii_rx.sv - RGMII DDR receive capture, GMII rebuild and preamble-stripping framer (optional in-band status: RGMII_INBAND_STATUS_EN)
module rgmii_to_gmii_rx #(
  parameter int MAX_PREAMBLE = 7,
  parameter int CNT_W        = 16
) (
  input  logic             rgmii_rx_clk,
  input  logic             reset_n,
  input  logic [3:0]       rgmii_rxd,
  input  logic             rgmii_rxctl,
  output logic [7:0]       gmii_rxd,
  output logic             gmii_rxdv,
  output logic             gmii_rxer,
  output logic [7:0]       pkt_data,
  output logic             pkt_valid,
  output logic             pkt_sof,
  output logic             pkt_eof,
  output logic             pkt_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             full_duplex
);

  localparam int PC_W = ($clog2(MAX_PREAMBLE + 1) < 1) ? 1 : $clog2(MAX_PREAMBLE + 1);
  localparam logic [PC_W-1:0] PRE_MAX = PC_W'(MAX_PREAMBLE);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

  logic [3:0] rxd_lo;
  logic [3:0] rxd_hi;
  logic       ctl_r;
  logic       ctl_f;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pre_cnt, pre_cnt_nxt;
  logic [7:0]      hold_data, hold_data_nxt;
  logic            hold_vld, hold_vld_nxt;
  logic            sof_pend, sof_pend_nxt;
  logic            err_flag, err_flag_nxt;
  logic [7:0]      pkt_data_nxt;
  logic            pkt_valid_nxt;
  logic            pkt_sof_nxt;
  logic            pkt_eof_nxt;
  logic            pkt_err_nxt;
  logic            frame_inc;
  logic            err_inc;

  // Rising-edge half of the DDR capture: low nibble and RX_DV.
  always_ff @(posedge rgmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_lo <= 4'h0;
      ctl_r  <= 1'b0;
    end else begin
      rxd_lo <= rgmii_rxd;
      ctl_r  <= rgmii_rxctl;
    end
  end

  // Falling-edge half of the DDR capture: high nibble and RX_DV^RX_ER.
  always_ff @(negedge rgmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_hi <= 4'h0;
      ctl_f  <= 1'b0;
    end else begin
      rxd_hi <= rgmii_rxd;
      ctl_f  <= rgmii_rxctl;
    end
  end

  // Reassemble both halves into one GMII byte on the next rising edge.
  always_ff @(posedge rgmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      gmii_rxd  <= 8'h00;
      gmii_rxdv <= 1'b0;
      gmii_rxer <= 1'b0;
    end else begin
      gmii_rxd  <= {rxd_hi, rxd_lo};
      gmii_rxdv <= ctl_r;
      gmii_rxer <= ctl_r ^ ctl_f;
    end
  end

  // Framer state, holding register and registered payload outputs.
  always_ff @(posedge rgmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pre_cnt   <= '0;
      hold_data <= 8'h00;
      hold_vld  <= 1'b0;
      sof_pend  <= 1'b0;
      err_flag  <= 1'b0;
      pkt_data  <= 8'h00;
      pkt_valid <= 1'b0;
      pkt_sof   <= 1'b0;
      pkt_eof   <= 1'b0;
      pkt_err   <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      pre_cnt   <= pre_cnt_nxt;
      hold_data <= hold_data_nxt;
      hold_vld  <= hold_vld_nxt;
      sof_pend  <= sof_pend_nxt;
      err_flag  <= err_flag_nxt;
      pkt_data  <= pkt_data_nxt;
      pkt_valid <= pkt_valid_nxt;
      pkt_sof   <= pkt_sof_nxt;
      pkt_eof   <= pkt_eof_nxt;
      pkt_err   <= pkt_err_nxt;
      frame_cnt <= frame_cnt + CNT_W'(frame_inc);
      err_cnt   <= err_cnt + CNT_W'(err_inc);
    end
  end

  // Next-state and payload decisions; one byte of look-ahead lets eof ride on the last byte.
  always_comb begin
    state_nxt     = state;
    pre_cnt_nxt   = pre_cnt;
    hold_data_nxt = hold_data;
    hold_vld_nxt  = hold_vld;
    sof_pend_nxt  = sof_pend;
    err_flag_nxt  = err_flag;
    pkt_data_nxt  = 8'h00;
    pkt_valid_nxt = 1'b0;
    pkt_sof_nxt   = 1'b0;
    pkt_eof_nxt   = 1'b0;
    pkt_err_nxt   = 1'b0;
    frame_inc     = 1'b0;
    err_inc       = 1'b0;
    case (state)
      S_IDLE: begin
        if (gmii_rxdv) begin
          if (gmii_rxd == 8'h55) begin
            state_nxt   = S_PRE;
            pre_cnt_nxt = PC_ONE;
          end else begin
            state_nxt = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!gmii_rxdv) begin
          state_nxt = S_IDLE;
        end else if (gmii_rxd == 8'hD5) begin
          state_nxt    = S_DATA;
          hold_vld_nxt = 1'b0;
          sof_pend_nxt = 1'b1;
          err_flag_nxt = 1'b0;
        end else if ((gmii_rxd == 8'h55) && (pre_cnt < PRE_MAX)) begin
          pre_cnt_nxt = pre_cnt + PC_ONE;
        end else begin
          state_nxt = S_DROP;
          err_inc   = 1'b1;
        end
      end
      S_DATA: begin
        if (gmii_rxdv) begin
          err_flag_nxt = err_flag | gmii_rxer;
          if (hold_vld) begin
            pkt_valid_nxt = 1'b1;
            pkt_data_nxt  = hold_data;
            pkt_sof_nxt   = sof_pend;
            sof_pend_nxt  = 1'b0;
          end
          hold_data_nxt = gmii_rxd;
          hold_vld_nxt  = 1'b1;
        end else begin
          if (hold_vld) begin
            pkt_valid_nxt = 1'b1;
            pkt_data_nxt  = hold_data;
            pkt_sof_nxt   = sof_pend;
            pkt_eof_nxt   = 1'b1;
            pkt_err_nxt   = err_flag | gmii_rxer;
            frame_inc     = 1'b1;
            err_inc       = err_flag | gmii_rxer;
          end
          hold_vld_nxt = 1'b0;
          sof_pend_nxt = 1'b0;
          err_flag_nxt = 1'b0;
          state_nxt    = S_IDLE;
        end
      end
      S_DROP: begin
        if (!gmii_rxdv) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef RGMII_INBAND_STATUS_EN
  logic [3:0] last_nib;
  logic       last_vld;

  // In-band status: accept an idle nibble only when it repeats on consecutive cycles.
  always_ff @(posedge rgmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_nib    <= 4'h0;
      last_vld    <= 1'b0;
      link_up     <= 1'b0;
      link_speed  <= 2'b00;
      full_duplex <= 1'b0;
    end else if (!ctl_r && !ctl_f) begin
      last_nib <= rxd_lo;
      last_vld <= 1'b1;
      if (last_vld && (last_nib == rxd_lo)) begin
        link_up     <= rxd_lo[0];
        link_speed  <= rxd_lo[2:1];
        full_duplex <= rxd_lo[3];
      end
    end else begin
      last_vld <= 1'b0;
    end
  end
`else
  // Without in-band status the link is reported up at gigabit full duplex once out of reset.
  always_ff @(posedge rgmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      link_up <= 1'b0;
    end else begin
      link_up <= 1'b1;
    end
  end

  assign link_speed  = 2'b10;
  assign full_duplex = 1'b1;
`endif

endmodule

// File: tb/tb_rgmii_to_gmii_rx.sv
// tb/tb_rgmii_to_gmii_rx.sv - self-checking bench for rgmii_to_gmii_rx
module tb_rgmii_to_gmii_rx;

  localparam int MAXP = 7;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    rgmii_rxd = 4'h0;
  logic          rgmii_rxctl = 1'b0;
  logic [7:0]    gmii_rxd;
  logic          gmii_rxdv;
  logic          gmii_rxer;
  logic [7:0]    pkt_data;
  logic          pkt_valid;
  logic          pkt_sof;
  logic          pkt_eof;
  logic          pkt_err;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] err_cnt;
  logic          link_up;
  logic [1:0]    link_speed;
  logic          full_duplex;

  rgmii_to_gmii_rx #(.MAX_PREAMBLE(MAXP), .CNT_W(CW)) dut (
    .rgmii_rx_clk(clk),
    .reset_n(reset_n),
    .rgmii_rxd(rgmii_rxd),
    .rgmii_rxctl(rgmii_rxctl),
    .gmii_rxd(gmii_rxd),
    .gmii_rxdv(gmii_rxdv),
    .gmii_rxer(gmii_rxer),
    .pkt_data(pkt_data),
    .pkt_valid(pkt_valid),
    .pkt_sof(pkt_sof),
    .pkt_eof(pkt_eof),
    .pkt_err(pkt_err),
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt),
    .link_up(link_up),
    .link_speed(link_speed),
    .full_duplex(full_duplex)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic       err;
    logic [7:0] data;
  } pkt_t;

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic       cr;
    logic       cf;
    logic [7:0] rxd;
    logic       dv;
    logic       er;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  pkt_t got_q[$];
  pkt_t exp_q[$];
  int   gap_errs = 0;
  logic in_pkt = 1'b0;
  time  sof_time = 0;
  time  last_lo_time = 0;
  int   exp_frames = 0;
  int   exp_errs = 0;
  logic [7:0] fb[$];
  logic       fe[$];
  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload monitor: records every pkt_valid beat and flags broken sof..eof runs.
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      in_pkt = 1'b0;
    end else if (pkt_valid) begin
      got_q.push_back({pkt_sof, pkt_eof, pkt_err, pkt_data});
      if (!in_pkt && !pkt_sof) gap_errs++;
      if (in_pkt && pkt_sof) gap_errs++;
      if (pkt_sof) sof_time = $time;
      in_pkt = !pkt_eof;
    end else if (in_pkt) begin
      gap_errs++;
    end
  end

  task automatic drive_raw(input logic [3:0] lo, input logic [3:0] hi, input logic cr, input logic cf);
    @(negedge clk);
    #2;
    rgmii_rxd   = lo;
    rgmii_rxctl = cr;
    @(posedge clk);
    last_lo_time = $time;
    #2;
    rgmii_rxd   = hi;
    rgmii_rxctl = cf;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic dv, input logic er);
    drive_raw(b[3:0], b[7:4], dv, dv ^ er);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_byte(8'h0D, 1'b0, 1'b0);
  endtask

  // Reference model: whole-frame view of what the MAC side should receive.
  task automatic model_frame();
    int   n = 0;
    int   last;
    logic anyerr = 1'b0;
    pkt_t p;
    if (fb.size() == 0) return;
    while (n < fb.size() && fb[n] == 8'h55) n++;
    if (n == 0) return;
    if (n > MAXP) begin exp_errs++; return; end
    if (n == fb.size()) return;
    if (fb[n] != 8'hD5) begin exp_errs++; return; end
    if (n + 1 == fb.size()) return;
    last = fb.size() - 1;
    for (int i = n + 1; i <= last; i++) anyerr = anyerr | fe[i];
    for (int i = n + 1; i <= last; i++) begin
      p.sof  = (i == n + 1);
      p.eof  = (i == last);
      p.err  = (i == last) && anyerr;
      p.data = fb[i];
      exp_q.push_back(p);
    end
    exp_frames++;
    if (anyerr) exp_errs++;
  endtask

  task automatic compare_stream(input string name);
    int n;
    chk({name, " beats"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, " beat"}, {21'd0, got_q[i]}, {21'd0, exp_q[i]});
    chk({name, " frame_cnt"}, frame_cnt, exp_frames);
    chk({name, " err_cnt"}, err_cnt, exp_errs);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_frame(input int gap, output time t_first);
    int fp = 0;
    t_first = 0;
    while (fp < fb.size() && fb[fp] == 8'h55) fp++;
    fp++;
    for (int i = 0; i < fb.size(); i++) begin
      drive_byte(fb[i], 1'b1, fe[i]);
      if (i == fp) t_first = last_lo_time;
    end
    idle(gap);
    model_frame();
  endtask

  task automatic build(input int npre, input logic sfd, input int plen);
    fb.delete();
    fe.delete();
    repeat (npre) begin fb.push_back(8'h55); fe.push_back(1'b0); end
    if (sfd) begin fb.push_back(8'hD5); fe.push_back(1'b0); end
    for (int i = 1; i <= plen; i++) begin fb.push_back(8'(i)); fe.push_back(1'b0); end
  endtask

  initial begin
    time t_first;
    int  sel;
    int  npre;
    int  plen;

    vt[0] = '{4'h5, 4'hA, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vt[1] = '{4'h5, 4'hA, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    vt[2] = '{4'h3, 4'hC, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1};
    vt[3] = '{4'hF, 4'h0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0};
    vt[4] = '{4'h0, 4'hF, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0};
    vt[5] = '{4'hE, 4'h7, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset gmii_rxd", gmii_rxd, 0);
    chk("reset gmii_rxdv", gmii_rxdv, 0);
    chk("reset gmii_rxer", gmii_rxer, 0);
    chk("reset pkt_valid", pkt_valid, 0);
    chk("reset pkt_sof/eof/err", {pkt_sof, pkt_eof, pkt_err}, 0);
    chk("reset pkt_data", pkt_data, 0);
    chk("reset frame_cnt", frame_cnt, 0);
    chk("reset err_cnt", err_cnt, 0);
    chk("reset link_up", link_up, 0);
`ifndef RGMII_INBAND_STATUS_EN
    chk("reset link_speed", link_speed, 2'b10);
    chk("reset full_duplex", full_duplex, 1);
`endif
    @(negedge clk);
    #2;
    reset_n = 1'b1;
`ifndef RGMII_INBAND_STATUS_EN
    @(posedge clk);
    #1;
    chk("link_up after reset", link_up, 1);
`endif

    for (int i = 0; i < 6; i++) begin
      drive_raw(vt[i].lo, vt[i].hi, vt[i].cr, vt[i].cf);
      @(posedge clk);
      #1;
      chk("vec gmii_rxd", gmii_rxd, vt[i].rxd);
      chk("vec gmii_rxdv", gmii_rxdv, vt[i].dv);
      chk("vec gmii_rxer", gmii_rxer, vt[i].er);
    end
    idle(4);
    compare_stream("vectors");

    build(7, 1'b1, 60);
    send_frame(6, t_first);
    chk("normal pkt_valid cycles", got_q.size(), 60);
    chk("normal sof latency", 32'(sof_time - t_first), 31);
    compare_stream("normal");
    chk("normal frame_cnt", frame_cnt, 1);

    build(7, 1'b1, 60);
    fe[8 + 9] = 1'b1;
    send_frame(6, t_first);
    compare_stream("error frame");
    chk("error frame err_cnt", err_cnt, 1);

    build(3, 1'b0, 0);
    fb.push_back(8'h77); fe.push_back(1'b0);
    fb.push_back(8'hD5); fe.push_back(1'b0);
    fb.push_back(8'h01); fe.push_back(1'b0);
    send_frame(5, t_first);
    compare_stream("bad preamble");
    chk("bad preamble err_cnt", err_cnt, 2);

    build(8, 1'b1, 5);
    send_frame(5, t_first);
    compare_stream("long preamble");
    chk("long preamble err_cnt", err_cnt, 3);

    build(7, 1'b1, 0);
    send_frame(5, t_first);
    compare_stream("zero payload");

    build(1, 1'b1, 0);
    fb.push_back(8'hAB); fe.push_back(1'b0);
    send_frame(5, t_first);
    compare_stream("single byte");

    for (int f = 0; f < 40; f++) begin
      fb.delete();
      fe.delete();
      sel  = $urandom_range(0, 9);
      npre = (sel == 3) ? $urandom_range(8, 10) : $urandom_range(1, 7);
      plen = (sel == 7 || sel == 9) ? 0 : $urandom_range(1, 24);
      if (sel == 8) fb.push_back(8'($urandom_range(0, 255)));
      repeat (npre) fb.push_back(8'h55);
      if (sel == 6) fb.push_back(8'($urandom_range(0, 255)));
      if (sel != 7) fb.push_back(8'hD5);
      repeat (plen) fb.push_back(8'($urandom_range(0, 255)));
      foreach (fb[i]) fe.push_back($urandom_range(0, 29) == 0);
      send_frame($urandom_range(4, 7), t_first);
      compare_stream("random");
    end

    build(7, 1'b1, 30);
    for (int i = 0; i < 28; i++) drive_byte(fb[i], 1'b1, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset gmii", {gmii_rxd, gmii_rxdv, gmii_rxer}, 0);
    chk("midreset pkt", {pkt_data, pkt_valid, pkt_sof, pkt_eof, pkt_err}, 0);
    chk("midreset frame_cnt", frame_cnt, 0);
    chk("midreset err_cnt", err_cnt, 0);
    chk("midreset link_up", link_up, 0);
    rgmii_rxd   = 4'h0;
    rgmii_rxctl = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    exp_frames = 0;
    exp_errs   = 0;
    idle(2);
    build(7, 1'b1, 0);
    repeat (20) begin fb.push_back(8'($urandom_range(0, 255))); fe.push_back(1'b0); end
    send_frame(6, t_first);
    compare_stream("after reset");

`ifdef RGMII_INBAND_STATUS_EN
    repeat (3) drive_raw(4'h2, 4'h2, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("inband status 0x2", {link_up, link_speed, full_duplex}, 4'b0010);
    repeat (2) drive_raw(4'hD, 4'hD, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("inband status 0xD", {link_up, link_speed, full_duplex}, 4'b1101);
    drive_raw(4'h0, 4'hD, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("inband glitch a", {link_up, link_speed, full_duplex}, 4'b1101);
    @(posedge clk);
    #1;
    chk("inband glitch b", {link_up, link_speed, full_duplex}, 4'b1101);
`endif

    chk("pkt_valid contiguity", gap_errs, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
